// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data requesters,
// with an in-order owner tag FIFO steering responses. Optional: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t          state;
  logic            owner;      // 0 = inst, 1 = data
  logic [DEPTH-1:0] tags;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;

  logic idle_sel;
  logic sel;
  logic sel_req;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;
  always_comb idle_sel = (inst_req && data_req) ? rr_ptr : data_req;
`else
  always_comb idle_sel = data_req;
`endif

  always_comb begin
    sel     = (state == S_LOCKED) ? owner : idle_sel;
    sel_req = sel ? data_req : inst_req;
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    mem_req = resetn && sel_req && !full;
    push    = mem_req && mem_addr_ok;
    head    = tags[rptr];
    // A response with nothing outstanding is dropped entirely.
    pop     = resetn && mem_data_ok && !empty;

    mem_wr    = sel ? data_wr    : inst_wr;
    mem_size  = sel ? data_size  : inst_size;
    mem_addr  = sel ? data_addr  : inst_addr;
    mem_wstrb = sel ? data_wstrb : inst_wstrb;
    mem_wdata = sel ? data_wdata : inst_wdata;

    inst_addr_ok = push && !sel;
    data_addr_ok = push && sel;
    inst_data_ok = pop && !head;
    data_data_ok = pop && head;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    outstanding  = count;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      owner  <= 1'b0;
      tags   <= '0;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
      // Lock is released only by an actual acceptance, so a stalled owner keeps the port.
      if (push) begin
        state <= S_IDLE;
      end else if (mem_req) begin
        state <= S_LOCKED;
        owner <= sel;
      end

      if (push) begin
        tags[wptr] <= sel;
        wptr       <= wptr + 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr     <= ~sel;
`endif
      end
      if (pop)
        rptr <= rptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default fixed-priority build, DEPTH=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  initial begin
    resetn = 0;
    inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = 4'h0; inst_wdata = '0;
    data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = 4'h0; data_wdata = '0;
    mem_rdata = '0;
    quiet();
    tick();
    // Everything gated while in reset
    inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    tick();
    chk("rst_outstanding", outstanding, 0);
    resetn = 1; quiet();

    // Basic routing
    inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
    #1;
    chk("basic_mem_req", mem_req, 1);
    chk("basic_mem_addr", mem_addr, 32'h1C000000);
    chk("basic_inst_addr_ok", inst_addr_ok, 1);
    chk("basic_data_addr_ok", data_addr_ok, 0);
    tick();
    quiet();
    #1;
    chk("basic_outstanding", outstanding, 1);
    chk("basic_no_early_ok", inst_data_ok, 0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'h02800C0C;
    #1;
    chk("basic_inst_data_ok", inst_data_ok, 1);
    chk("basic_inst_rdata", inst_rdata, 32'h02800C0C);
    chk("basic_data_data_ok", data_data_ok, 0);
    tick();
    quiet();
    #1;
    chk("basic_drained", outstanding, 0);

    // Priority: data beats inst
    inst_req = 1; data_req = 1; data_wr = 1; data_addr = 32'h1C010000;
    data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF; mem_addr_ok = 1;
    #1;
    chk("prio_mem_addr_data", mem_addr, 32'h1C010000);
    chk("prio_mem_wr", mem_wr, 1);
    chk("prio_mem_wstrb", mem_wstrb, 4'hF);
    chk("prio_data_addr_ok", data_addr_ok, 1);
    chk("prio_inst_addr_ok0", inst_addr_ok, 0);
    tick();
    data_req = 0;
    #1;
    chk("prio_mem_addr_inst", mem_addr, 32'h1C000000);
    chk("prio_inst_addr_ok1", inst_addr_ok, 1);
    tick();
    quiet();
    mem_data_ok = 1; mem_rdata = 32'h11;
    #1;
    chk("prio_resp1_data", data_data_ok, 1);
    chk("prio_resp1_inst", inst_data_ok, 0);
    tick();
    mem_rdata = 32'h22;
    #1;
    chk("prio_resp2_inst", inst_data_ok, 1);
    chk("prio_resp2_data", data_data_ok, 0);
    tick();
    quiet();

    // Lock: inst stalled 3 cycles, data arrives in cycle 1
    inst_req = 1; inst_addr = 32'h1C000100;
    #1;
    chk("lock_c0_addr", mem_addr, 32'h1C000100);
    chk("lock_c0_ok", inst_addr_ok, 0);
    tick();
    data_req = 1;
    #1;
    chk("lock_c1_addr", mem_addr, 32'h1C000100);
    chk("lock_c1_data_ok", data_addr_ok, 0);
    tick();
    #1;
    chk("lock_c2_addr", mem_addr, 32'h1C000100);
    tick();
    mem_addr_ok = 1;
    #1;
    chk("lock_c3_addr", mem_addr, 32'h1C000100);
    chk("lock_c3_inst_ok", inst_addr_ok, 1);
    chk("lock_c3_data_ok", data_addr_ok, 0);
    tick();
    inst_req = 0;
    #1;
    chk("lock_c4_addr", mem_addr, 32'h1C010000);
    chk("lock_c4_data_ok", data_addr_ok, 1);
    tick();
    quiet();
    mem_data_ok = 1;
    #1;
    chk("lock_resp1_inst", inst_data_ok, 1);
    tick();
    #1;
    chk("lock_resp2_data", data_data_ok, 1);
    tick();
    quiet();

    // Ordering: inst, data, inst
    mem_addr_ok = 1;
    inst_req = 1;
    tick();
    inst_req = 0; data_req = 1;
    #1;
    chk("ord_data_accept", data_addr_ok, 1);
    tick();
    data_req = 0; inst_req = 1;
    #1;
    chk("ord_inst_accept", inst_addr_ok, 1);
    tick();
    quiet();
    #1;
    chk("ord_outstanding", outstanding, 3);
    mem_data_ok = 1; mem_rdata = 32'hA;
    #1;
    chk("ord_r1_inst", inst_data_ok, 1);
    chk("ord_r1_rdata", inst_rdata, 32'hA);
    chk("ord_r1_data", data_data_ok, 0);
    tick();
    mem_rdata = 32'hB;
    #1;
    chk("ord_r2_data", data_data_ok, 1);
    chk("ord_r2_rdata", data_rdata, 32'hB);
    chk("ord_r2_inst", inst_data_ok, 0);
    tick();
    mem_rdata = 32'hC;
    #1;
    chk("ord_r3_inst", inst_data_ok, 1);
    chk("ord_r3_rdata", inst_rdata, 32'hC);
    tick();
    quiet();

    // Full FIFO
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_fill_ok", inst_addr_ok, 1);
      tick();
    end
    #1;
    chk("full_outstanding", outstanding, 4);
    chk("full_mem_req", mem_req, 0);
    chk("full_inst_addr_ok", inst_addr_ok, 0);
    mem_data_ok = 1;
    #1;
    chk("full_no_bypass", mem_req, 0);
    chk("full_pop_ok", inst_data_ok, 1);
    tick();
    mem_data_ok = 0;
    #1;
    chk("full_after_pop_cnt", outstanding, 3);
    chk("full_reassert", mem_req, 1);
    tick();
    quiet();
    #1;
    chk("full_refill", outstanding, 4);

    // Reset mid-operation: drain to 2, stall inst into LOCKED, then reset
    mem_data_ok = 1;
    tick(); tick();
    mem_data_ok = 0;
    #1;
    chk("rstmid_two", outstanding, 2);
    inst_req = 1; inst_addr = 32'h1C000200;
    tick();
    resetn = 0;
    tick();
    resetn = 1; quiet();
    #1;
    chk("rstmid_outstanding", outstanding, 0);
    mem_data_ok = 1;
    #1;
    chk("rstmid_stray_inst", inst_data_ok, 0);
    chk("rstmid_stray_data", data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    inst_req = 1; data_req = 1; data_addr = 32'h1C010040;
    #1;
    chk("rstmid_cnt_after_stray", outstanding, 0);
    chk("rstmid_idle_prio", mem_addr, 32'h1C010040);
    tick();
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester of the pipeline. It sits between the IF/EXE request logic and the AXI bridge. Each cycle it grants at most one request and holds the grant until the address handshake completes. It records the owner of every accepted request in an in-order tag FIFO, so each returning `data_ok`/`rdata` reaches the requester that issued it.

## Interface
- `DEPTH`, default 4: maximum number of outstanding (address-accepted, data-pending) requests; power of two, minimum 2.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `inst_req`, `inst_wr`, `inst_size[1:0]`, `inst_addr[31:0]`, `inst_wstrb[3:0]`, `inst_wdata[31:0]` in: instruction-side request.
- `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32: instruction-side handshakes and read data.
- `data_req`, `data_wr`, `data_size[1:0]`, `data_addr[31:0]`, `data_wstrb[3:0]`, `data_wdata[31:0]` in: data-side request.
- `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32: data-side handshakes and read data.
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_addr[31:0]`, `mem_wstrb[3:0]`, `mem_wdata[31:0]` out: shared-port request.
- `mem_addr_ok` in 1, `mem_data_ok` in 1, `mem_rdata` in 32: shared-port handshakes and read data.
- `outstanding` out log2(DEPTH)+1: current FIFO occupancy, for debug and performance counters.

## Operation
- **Handshake.** A request is accepted in a cycle with `req && addr_ok`. A response is delivered in a cycle with `data_ok`. Responses return strictly in acceptance order.
- **Arbitration states.** The arbiter has two states, IDLE and LOCKED(owner).
  - In IDLE, the selected requester is chosen by the priority rule among the asserted `*_req`.
  - If `mem_req` is high and `mem_addr_ok` is low, the next state is LOCKED with the current owner.
  - In LOCKED, the owner stays selected regardless of the other requester. The owner's request fields pass through unchanged; the requester must hold them stable.
  - The arbiter returns to IDLE on the cycle `mem_addr_ok` is seen.
- **Priority (default).** Fixed priority: data beats inst.
- **Request mux.** The `mem_*` request fields are a combinational mux of the selected requester. `mem_req` = selected `req` && !fifo_full. `mem_addr_ok` is routed only to the selected requester. The non-selected requester sees `addr_ok=0`.
- **Tag FIFO.** DEPTH entries, 1-bit owner tag (0=inst, 1=data). Push on `mem_req && mem_addr_ok`. Pop on `mem_data_ok`. Read and write pointers wrap modulo DEPTH.
- **Response routing.** `mem_data_ok` is steered to the owner at the FIFO head. `mem_rdata` is broadcast to both `*_rdata`, and only the steered `data_ok` is high.
- **Full FIFO.** When `outstanding==DEPTH`, `mem_req` is forced 0. This holds even if a pop happens in the same cycle: no bypass, so one bubble is accepted.
- **Empty FIFO.** A `mem_data_ok` with the FIFO empty is a protocol error. It is dropped: no `*_data_ok` is raised and the pointers are unchanged.
- **Same-cycle push and pop** (not full): occupancy is unchanged and both pointers advance.

## Timing
- Request path is combinational: `*_req` → `mem_req` in 0 cycles, and `mem_addr_ok` → `*_addr_ok` in 0 cycles.
- Response path is combinational: `mem_data_ok` → `*_data_ok` in 0 cycles.
- The earliest response to a request accepted in cycle N is cycle N+1 (the tag is visible at the FIFO head after the push registers).
- Lock state, FIFO, and pointers are registered.
- **Reset (`resetn` low at a clk edge):** state returns to IDLE, the FIFO is emptied, both pointers return to 0, `outstanding` = 0, and the round-robin pointer returns to inst.
  - While `resetn` is low, `mem_req`, both `*_addr_ok` and both `*_data_ok` are forced 0.
- Reset mid-transaction discards all outstanding tags. The memory side is reset by the same signal.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: the IDLE-state choice when both requesters are asserted uses a 1-bit round-robin pointer.
  - The pointer names the requester that wins the next conflict.
  - On each accepted request, the pointer moves to the other requester.
  - A lone requester always wins.
- `ARB_ROUND_ROBIN_EN` not defined: fixed priority, data over inst, with no pointer register.
- LOCKED behaviour is identical in both builds.

## Test plan
- **Basic routing.** Inst read of 0x1C000000, memory `addr_ok` the same cycle, `data_ok` 2 cycles later with `rdata`=0x02800C0C → `inst_addr_ok` and `inst_data_ok` pulse once, `inst_rdata`=0x02800C0C, `data_data_ok` stays 0.
- **Priority.** Inst and data requests asserted together, store to 0x1C010000 with `wstrb`=0xF.
  - Default build: data is granted first and inst the next cycle.
  - `ARB_ROUND_ROBIN_EN` build: inst first after reset, then data.
- **Lock.** Inst request with `mem_addr_ok` held low for 3 cycles while `data_req` rises in cycle 1 → `mem_addr`=inst address for all 4 cycles, and data is granted the cycle after inst's `addr_ok`.
- **Ordering.** Accept inst, data, inst back-to-back, then 3 `mem_data_ok` pulses with rdata 0xA, 0xB, 0xC → inst gets 0xA, data gets 0xB, inst gets 0xC.
- **Full FIFO.** DEPTH=4 with 4 requests accepted and no responses → `outstanding`=4 and `mem_req`=0. After one `data_ok`, `mem_req` reasserts on the next cycle.
- **Reset mid-operation.** 2 requests outstanding, `resetn` low for 1 cycle → `outstanding`=0, state is IDLE, and a subsequent stray `mem_data_ok` raises no `*_data_ok`.
